// File: rtl/clk_div_multi.sv
// N-channel programmable clock/tick divider with boundary-aligned divisor updates
// and a shared phase-alignment input.
module clk_div_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 17,
    parameter int DEFAULT_DIV = 100000
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic [NUM_CH-1:0]       load_i,
    input  logic [NUM_CH*CNT_W-1:0] div_i,
    input  logic                    sync_i,
    output logic [NUM_CH-1:0]       clk_o,
    output logic [NUM_CH-1:0]       tick_o,
    output logic [NUM_CH-1:0]       pend_o
);

    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
    localparam logic [CNT_W-1:0] RST_DIV = (DEFAULT_DIV < 2) ? MIN_DIV : CNT_W'(DEFAULT_DIV);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] div_q, div_d;
        logic [CNT_W-1:0] pend_q, pend_d;
        logic             pv_q, pv_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic [CNT_W-1:0] req;
        logic [CNT_W-1:0] ld_val;
        logic [CNT_W-1:0] nxt_div;
        logic             wrap;

        assign req     = div_i[k*CNT_W +: CNT_W];
        assign ld_val  = (req < MIN_DIV) ? MIN_DIV : req;
        assign wrap    = en_i[k] & (cnt_q == div_q - CNT_W'(1));
        // Divisor adopted at a boundary: a same-cycle load beats an older pending value.
        assign nxt_div = load_i[k] ? ld_val : (pv_q ? pend_q : div_q);

        always_comb begin
            cnt_d  = cnt_q;
            div_d  = div_q;
            pend_d = pend_q;
            pv_d   = pv_q;
            clk_d  = en_i[k] & (cnt_q >= (div_q >> 1));
            tick_d = wrap & ~sync_i;
            if (!en_i[k]) begin
                cnt_d = '0;
                div_d = nxt_div;
                pv_d  = 1'b0;
            end else if (sync_i || wrap) begin
                cnt_d = '0;
                div_d = nxt_div;
                pv_d  = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (load_i[k]) begin
                    pend_d = ld_val;
                    pv_d   = 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q  <= '0;
                div_q  <= RST_DIV;
                pend_q <= RST_DIV;
                pv_q   <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                div_q  <= div_d;
                pend_q <= pend_d;
                pv_q   <= pv_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
            end
        end

        assign clk_o[k]  = clk_q;
        assign tick_o[k] = tick_q;
        assign pend_o[k] = pv_q;
    end

endmodule
